// File: rtl/pwm_multi_if.sv
// Control and output bundle for the multi-channel PWM generator.
// The register/control side is the master; the PWM block is the slave.
interface pwm_multi_if #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8
);
    logic                     EN;
    logic                     LOAD;
    logic [BITS-1:0]          PERIOD;
    logic [CHANNELS*BITS-1:0] DUTY;
    logic [CHANNELS-1:0]      POL;
    logic [CHANNELS-1:0]      OUTPUT;
    logic                     CYCLE_START;

    modport master (
        output EN, LOAD, PERIOD, DUTY, POL,
        input  OUTPUT, CYCLE_START
    );

    modport slave (
        input  EN, LOAD, PERIOD, DUTY, POL,
        output OUTPUT, CYCLE_START
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, per-channel duty and polarity,
// double-buffered period/duty that only commit at a period boundary or while idle.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    pwm_multi_if.slave  bus
);
    logic [BITS-1:0]          count_r;
    logic [BITS-1:0]          per_act_r;
    logic [BITS-1:0]          per_sh_r;
    logic [CHANNELS*BITS-1:0] duty_act_r;
    logic [CHANNELS*BITS-1:0] duty_sh_r;
    logic                     pending_r;
    logic [CHANNELS-1:0]      out_r;
    logic                     cs_r;

    logic                     terminal_s;
    logic                     commit_s;
    logic [BITS-1:0]          count_nxt_s;
    logic [CHANNELS-1:0]      active_s;

    // Boundary detection, commit decision and next counter value.
    always_comb begin
        terminal_s  = (count_r == per_act_r);
        commit_s    = pending_r & (~bus.EN | terminal_s);
        count_nxt_s = {BITS{1'b0}};
        if (bus.EN && !terminal_s) begin
            count_nxt_s = count_r + {{(BITS-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = {BITS{1'b0}};
        end
    end

    // Per-channel activity for the current count; unsigned compare gives 0% and 100% for free.
    always_comb begin
        active_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            active_s[c] = bus.EN & (count_r < duty_act_r[c*BITS +: BITS]);
        end
    end

    // Counter, shadow/active register pair and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r    <= {BITS{1'b0}};
            per_act_r  <= {BITS{1'b0}};
            per_sh_r   <= {BITS{1'b0}};
            duty_act_r <= {(CHANNELS*BITS){1'b0}};
            duty_sh_r  <= {(CHANNELS*BITS){1'b0}};
            pending_r  <= 1'b0;
            out_r      <= {CHANNELS{1'b0}};
            cs_r       <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (commit_s) begin
                per_act_r  <= per_sh_r;
                duty_act_r <= duty_sh_r;
            end
            // A LOAD coinciding with a commit keeps the new values pending for the next boundary.
            if (bus.LOAD) begin
                per_sh_r  <= bus.PERIOD;
                duty_sh_r <= bus.DUTY;
                pending_r <= 1'b1;
            end else if (commit_s) begin
                pending_r <= 1'b0;
            end
            out_r <= active_s ^ bus.POL;
            cs_r  <= bus.EN & (count_r == {BITS{1'b0}});
        end
    end

    assign bus.OUTPUT      = out_r;
    assign bus.CYCLE_START = cs_r;
endmodule
